// File: rtl/serial_tofed_tx_2of5_if.sv
// Digit handshake and serial output bundle for the 2-of-5 serial transmitter.
//   digit_in      [3:0] BCD digit offered by the source (0-9 legal)
//   digit_valid         source offers digit_in this cycle
//   digit_ready         transmitter accepts digit_in this cycle
//   dout                serial data, code word MSB first
//   frame_start         dout carries bit 0 (MSB) of a frame
//   frame_is_data       current frame carries a digit rather than filler
//   code_err            one-cycle pulse after an illegal digit was accepted
// master = digit source / line observer, slave = transmitter.
interface serial_tofed_tx_2of5_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       dout;
  logic       frame_start;
  logic       frame_is_data;
  logic       code_err;

  modport master (
    output digit_in,
    output digit_valid,
    input  digit_ready,
    input  dout,
    input  frame_start,
    input  frame_is_data,
    input  code_err
  );

  modport slave (
    input  digit_in,
    input  digit_valid,
    output digit_ready,
    output dout,
    output frame_start,
    output frame_is_data,
    output code_err
  );
endinterface

// File: rtl/serial_tofed_tx_2of5.sv
// Serial 2-of-5 transmitter. Accepts BCD digits over a valid/ready handshake,
// encodes each as a 5-bit 7-4-2-1-0 code word and shifts it out MSB first in
// back-to-back 5-cycle frames aligned to reset. Idle frames are filler 00000.
// Ports:
//   clk     rising-edge clock
//   resetH  asynchronous active-high reset
//   tx      handshake / serial output bundle (slave side)
module serial_tofed_tx_2of5 (
  input  logic                         clk,
  input  logic                         resetH,
  serial_tofed_tx_2of5_if.slave        tx
);

  typedef enum logic [2:0] {B0, B1, B2, B3, B4} state_t;

  state_t     state_q, state_d;
  logic [4:0] sh_q, sh_d;
  logic [4:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       code_err_q, code_err_d;
  logic       is_data_q, is_data_d;

  logic       ready;
  logic       accept;
  logic       legal;
  logic [4:0] code_in;

  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] c;
    case (d)
      4'd0:    c = 5'b11000;
      4'd1:    c = 5'b00011;
      4'd2:    c = 5'b00101;
      4'd3:    c = 5'b00110;
      4'd4:    c = 5'b01001;
      4'd5:    c = 5'b01010;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b10001;
      4'd8:    c = 5'b10010;
      4'd9:    c = 5'b10100;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

  // The B4 load frees the hold register in the same cycle, so a new digit can
  // be taken there even when the hold is full.
  assign ready   = !hold_full_q || (state_q == B4);
  assign accept  = tx.digit_valid && ready;
  assign legal   = (tx.digit_in <= 4'd9);
  assign code_in = encode(tx.digit_in);

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q     <= B0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      code_err_q  <= 1'b0;
      is_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      code_err_q  <= code_err_d;
      is_data_q   <= is_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = {sh_q[3:0], 1'b0};
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    is_data_d   = is_data_q;
    // Illegal digits complete the handshake but are never queued.
    code_err_d  = accept && !legal;

    case (state_q)
      B0: state_d = B1;
      B1: state_d = B2;
      B2: state_d = B3;
      B3: state_d = B4;
      B4: state_d = B0;
      default: state_d = B0;
    endcase

    if (state_q == B4) begin
      // Frame load: hold register first, then same-cycle bypass, then filler.
      if (hold_full_q) begin
        sh_d        = hold_q;
        is_data_d   = 1'b1;
        hold_full_d = accept && legal;
        if (accept && legal) begin
          hold_d = code_in;
        end
      end else if (accept && legal) begin
        sh_d      = code_in;
        is_data_d = 1'b1;
      end else begin
        sh_d      = '0;
        is_data_d = 1'b0;
      end
    end else if (accept && legal) begin
      // Outside B4 an accept only happens with the hold empty.
      hold_d      = code_in;
      hold_full_d = 1'b1;
    end
  end

  assign tx.digit_ready   = ready;
  assign tx.dout          = sh_q[4];
  assign tx.frame_start   = (state_q == B0);
  assign tx.frame_is_data = is_data_q;
  assign tx.code_err      = code_err_q;

endmodule
